// File: rtl/sdpsram_pkg.sv
// Shared types and legal-value constants for the simple dual-port SRAM.
// The clear-engine state encoding lives here so the top and sub-module agree on it.
package sdpsram_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 2;

    localparam int WR_THRU_OLD = 0;
    localparam int WR_THRU_NEW = 1;

endpackage : sdpsram_pkg

// File: rtl/sdpsram_clr.sv
// Power-up clear engine: walks every address once writing zero, then parks in RUN.
// Busy is high for exactly 2**BW_ADDR cycles after reset release.
module sdpsram_clr
    import sdpsram_pkg::*;
#(
    parameter int BW_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output logic               o_busy,
    output logic               o_clr_we,
    output logic [BW_ADDR-1:0] o_clr_addr
);

    localparam logic [BW_ADDR-1:0] LAST_ADDR = '1;

    clr_state_e         state_q;
    clr_state_e         state_d;
    logic [BW_ADDR-1:0] cnt_q;
    logic [BW_ADDR-1:0] cnt_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= CLR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The edge that clears the last address is also the edge that enters RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy     = (state_q == CLR);
        o_clr_we   = (state_q == CLR);
        o_clr_addr = cnt_q;
    end

endmodule : sdpsram_clr

// File: rtl/sdpsram.sv
// Simple dual-port SRAM with byte enables, selectable read latency and collision policy.
// The array is never reset; it is zeroed by the clear engine after every reset.
module sdpsram
    import sdpsram_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5,
    parameter int RD_LAT  = 1,
    parameter int WR_THRU = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_wcen,
    input  logic [BW_ADDR-1:0]   i_waddr,
    input  logic [BW_DATA-1:0]   i_wdata,
    input  logic [BW_DATA/8-1:0] i_wbe,
    input  logic                 i_rcen,
    input  logic [BW_ADDR-1:0]   i_raddr,
    input  logic                 i_roen,
    output logic [BW_DATA-1:0]   o_rdata,
    output logic                 o_rvalid,
    output logic                 o_init_busy
);

    localparam int DEPTH      = 2 ** BW_ADDR;
    localparam int NUM_BYTES  = BW_DATA / 8;
    localparam bit USE_LAT2   = (RD_LAT == RD_LAT_MAX);
    localparam bit WRITE_THRU = (WR_THRU == WR_THRU_NEW);

    logic [BW_DATA-1:0] mem [DEPTH];

    logic               clr_busy;
    logic               clr_we;
    logic [BW_ADDR-1:0] clr_addr;

    logic               run;
    logic [BW_DATA-1:0] byte_mask;
    logic               wr_en;
    logic               rd_fire;
    logic               collide;
    logic [BW_DATA-1:0] old_word;
    logic [BW_DATA-1:0] wr_word;
    logic [BW_DATA-1:0] rd_word;

    logic               p1_valid_q;
    logic               p1_valid_d;
    logic [BW_DATA-1:0] p1_data_q;
    logic [BW_DATA-1:0] p1_data_d;
    logic               rvalid_q;
    logic               rvalid_d;
    logic [BW_DATA-1:0] rdata_q;
    logic [BW_DATA-1:0] rdata_d;
    logic               done_valid;
    logic [BW_DATA-1:0] done_data;

    sdpsram_clr #(
        .BW_ADDR (BW_ADDR)
    ) u_clr (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .o_busy     (clr_busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // The merged write word doubles as the write-through collision result.
    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            byte_mask[8*k +: 8] = {8{i_wbe[k]}};
        end
        run      = !clr_busy;
        wr_en    = run && i_wcen && (|i_wbe);
        rd_fire  = run && i_rcen;
        old_word = mem[i_waddr];
        wr_word  = (old_word & ~byte_mask) | (i_wdata & byte_mask);
        collide  = wr_en && (i_waddr == i_raddr);
        rd_word  = (WRITE_THRU && collide) ? wr_word : mem[i_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[i_waddr] <= wr_word;
        end
    end

    // Stage 1 is only on the completion path when two-cycle latency is selected.
    always_comb begin
        p1_valid_d = rd_fire;
        p1_data_d  = rd_fire ? rd_word : p1_data_q;
        done_valid = USE_LAT2 ? p1_valid_q : rd_fire;
        done_data  = USE_LAT2 ? p1_data_q : rd_word;
        rvalid_d   = done_valid;
        rdata_d    = done_valid ? done_data : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_data_q  <= p1_data_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        o_rdata     = i_roen ? rdata_q : '0;
        o_rvalid    = rvalid_q;
        o_init_busy = clr_busy;
    end

endmodule : sdpsram

// File: tb/tb_sdpsram.sv
// Directed bench driving two SRAM instances in lockstep: dut_a (1-cycle, write-through)
// and dut_b (2-cycle, read-old), each checked against hand-computed values.
module tb_sdpsram;

    logic        i_clk;
    logic        i_rstn;
    logic        i_wcen;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wbe;
    logic        i_rcen;
    logic [4:0]  i_raddr;
    logic        i_roen;

    logic [31:0] rdata_a;
    logic        rvalid_a;
    logic        busy_a;
    logic [31:0] rdata_b;
    logic        rvalid_b;
    logic        busy_b;

    int          checks;
    int          errors;
    logic [31:0] model [32];

    sdpsram #(
        .BW_DATA (32), .BW_ADDR (5), .RD_LAT (1), .WR_THRU (1)
    ) dut_a (
        .i_clk (i_clk), .i_rstn (i_rstn),
        .i_wcen (i_wcen), .i_waddr (i_waddr), .i_wdata (i_wdata), .i_wbe (i_wbe),
        .i_rcen (i_rcen), .i_raddr (i_raddr), .i_roen (i_roen),
        .o_rdata (rdata_a), .o_rvalid (rvalid_a), .o_init_busy (busy_a)
    );

    sdpsram #(
        .BW_DATA (32), .BW_ADDR (5), .RD_LAT (2), .WR_THRU (0)
    ) dut_b (
        .i_clk (i_clk), .i_rstn (i_rstn),
        .i_wcen (i_wcen), .i_waddr (i_waddr), .i_wdata (i_wdata), .i_wbe (i_wbe),
        .i_rcen (i_rcen), .i_raddr (i_raddr), .i_roen (i_roen),
        .o_rdata (rdata_b), .o_rvalid (rvalid_b), .o_init_busy (busy_b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wcen, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] wbe, input logic rcen, input logic [4:0] raddr);
        i_wcen  = wcen;
        i_waddr = waddr;
        i_wdata = wdata;
        i_wbe   = wbe;
        i_rcen  = rcen;
        i_raddr = raddr;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Counts cycles with busy high after release; also flags any rvalid seen while clearing.
    task automatic measureClear(input string tag);
        int  n_a;
        int  n_b;
        logic any_rv;
        n_a    = 0;
        n_b    = 0;
        any_rv = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (busy_a) n_a++;
            if (busy_b) n_b++;
            any_rv = any_rv | rvalid_a | rvalid_b;
            if (!busy_a && !busy_b) break;
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        checkOutput({tag, "_busy_cycles_a"}, 32'(n_a), 32'd32);
        checkOutput({tag, "_busy_cycles_b"}, 32'(n_b), 32'd32);
        checkOutput({tag, "_no_rvalid"}, 32'(any_rv), 32'd0);
    endtask

    // Back-to-back reads of 0..31; dut_b lags dut_a by one cycle.
    task automatic readBurst(input string tag);
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        tick();
        for (int i = 0; i <= 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, (i < 32), 5'(i));
            tick();
            if (i < 32) begin
                checkOutput({tag, "_rvalid_a"}, 32'(rvalid_a), 32'd1);
                checkOutput({tag, "_rdata_a"}, rdata_a, model[i]);
            end else begin
                checkOutput({tag, "_rvalid_a_end"}, 32'(rvalid_a), 32'd0);
            end
            if (i == 0) begin
                checkOutput({tag, "_rvalid_b_first"}, 32'(rvalid_b), 32'd0);
            end else begin
                checkOutput({tag, "_rvalid_b"}, 32'(rvalid_b), 32'd1);
                checkOutput({tag, "_rdata_b"}, rdata_b, model[i-1]);
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        tick();
    endtask

    // One read (write inputs may already be set up for a collision); checks both latencies.
    task automatic readOne(input string tag, input logic [4:0] addr,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
        i_rcen  = 1'b1;
        i_raddr = addr;
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        checkOutput({tag, "_rvalid_a"}, 32'(rvalid_a), 32'd1);
        checkOutput({tag, "_rdata_a"}, rdata_a, exp_a);
        checkOutput({tag, "_rvalid_b_early"}, 32'(rvalid_b), 32'd0);
        tick();
        checkOutput({tag, "_rvalid_a_drop"}, 32'(rvalid_a), 32'd0);
        checkOutput({tag, "_rdata_a_hold"}, rdata_a, exp_a);
        checkOutput({tag, "_rvalid_b"}, 32'(rvalid_b), 32'd1);
        checkOutput({tag, "_rdata_b"}, rdata_b, exp_b);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rstn = 1'b0;
        i_roen = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        tick();
        tick();

        checkOutput("rst_busy_a", 32'(busy_a), 32'd1);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd1);
        checkOutput("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        checkOutput("rst_rdata_a", rdata_a, 32'h0);
        checkOutput("rst_rdata_b", rdata_b, 32'h0);

        // User traffic during the clear must be ignored.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd0);
        i_rstn = 1'b1;
        measureClear("pwr");
        readBurst("zero");

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i), 4'hF, 1'b0, 5'd0);
            model[i] = 32'(i);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        readBurst("wr");

        applyStimulus(1'b1, 5'd3, 32'hAABB_CCDD, 4'hF, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h1122_3344, 4'b0101, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h5555_5555, 4'b0000, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        readOne("be", 5'd3, 32'hAA22_CC44, 32'hAA22_CC44);
        readOne("be0", 5'd4, 32'h0000_0004, 32'h0000_0004);

        applyStimulus(1'b1, 5'd7, 32'h0, 4'hF, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF, 1'b0, 5'd0);
        readOne("coll", 5'd7, 32'hDEAD_BEEF, 32'h0);
        readOne("coll_after", 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 5'd7, 32'h1234_5678, 4'b0011, 1'b0, 5'd0);
        readOne("coll_part", 5'd7, 32'hDEAD_5678, 32'hDEAD_BEEF);
        readOne("coll_part_after", 5'd7, 32'hDEAD_5678, 32'hDEAD_5678);

        i_roen = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
        checkOutput("gate_rvalid_a", 32'(rvalid_a), 32'd1);
        checkOutput("gate_rdata_a", rdata_a, 32'h0);
        tick();
        checkOutput("gate_rvalid_b", 32'(rvalid_b), 32'd1);
        checkOutput("gate_rdata_b", rdata_b, 32'h0);
        i_roen = 1'b1;
        #1;
        checkOutput("ungate_rdata_a", rdata_a, 32'hAA22_CC44);
        checkOutput("ungate_rdata_b", rdata_b, 32'hAA22_CC44);

        // Asynchronous reset with a read in flight, then a second reset partway through the clear.
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3);
        tick();
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("async_rdata_a", rdata_a, 32'h0);
        checkOutput("async_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("async_busy_a", 32'(busy_a), 32'd1);
        checkOutput("async_busy_b", 32'(busy_b), 32'd1);
        tick();
        checkOutput("async_rvalid_b", 32'(rvalid_b), 32'd0);
        i_rstn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("mid_busy_a_pre", 32'(busy_a), 32'd1);
        i_rstn = 1'b0;
        #1;
        checkOutput("mid_busy_a", 32'(busy_a), 32'd1);
        checkOutput("mid_busy_b", 32'(busy_b), 32'd1);
        tick();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3);
        i_rstn = 1'b1;
        measureClear("mid");
        readOne("post_clr", 5'd3, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sdpsram

// File: doc/sdpsram.md
SDPSRAM -- requirements
Module: sdpsram

Interface
REQ-001 SHALL have parameter BW_DATA, default 32, data width in bits; legal values are multiples of 8, from 8 to 128.
REQ-002 SHALL have parameter BW_ADDR, default 5, address width; DEPTH = 2**BW_ADDR words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 or 2.
REQ-004 SHALL have parameter WR_THRU, default 1; 1 = write-through on collision, 0 = read-old on collision.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_wcen, input, 1 bit: write-port enable.
REQ-008 SHALL have port i_waddr, input, BW_ADDR bits: write address.
REQ-009 SHALL have port i_wdata, input, BW_DATA bits: write data.
REQ-010 SHALL have port i_wbe, input, BW_DATA/8 bits: byte enables; bit k covers data bits [8k+7:8k].
REQ-011 SHALL have port i_rcen, input, 1 bit: read-port enable.
REQ-012 SHALL have port i_raddr, input, BW_ADDR bits: read address.
REQ-013 SHALL have port i_roen, input, 1 bit: output enable; gates o_rdata.
REQ-014 SHALL have port o_rdata, output, BW_DATA bits: read data.
REQ-015 SHALL have port o_rvalid, output, 1 bit: one-cycle pulse marking new read data.
REQ-016 SHALL have port o_init_busy, output, 1 bit: high while the clear engine runs.

Function
REQ-017 SHALL contain two states, CLR and RUN.
  - Reset forces CLR.
  - CLR writes zero to one address per cycle, 0 through DEPTH-1, using an internal counter.
  - CLR moves to RUN on the cycle that writes DEPTH-1.
  - RUN is held until the next reset.
REQ-018 SHALL drive o_init_busy = 1 in CLR and 0 in RUN; the full clear takes exactly DEPTH cycles after i_rstn deasserts.
REQ-019 SHALL ignore i_wcen and i_rcen in CLR: no user write, and no o_rvalid from a read accepted in CLR.
REQ-020 SHALL perform a write in RUN when i_wcen=1: only bytes with i_wbe[k]=1 are updated at the edge; i_wbe=0 is a no-op.
REQ-021 SHALL accept a read in RUN when i_rcen=1 at an edge.
  - RD_LAT=1: data appears on o_rdata after that edge, with o_rvalid=1 for one cycle.
  - RD_LAT=2: both appear one edge later.
REQ-022 SHALL accept back-to-back reads every cycle, each producing its own o_rvalid pulse in order.
REQ-023 SHALL hold the internal read register when no read completes; o_rvalid=0 on those cycles.
REQ-024 SHALL drive o_rdata = 0 combinationally while i_roen=0, without disturbing the held register; o_rvalid is not gated by i_roen.
REQ-025 SHALL resolve a collision (i_wcen=1, i_rcen=1, i_waddr=i_raddr, same edge) as follows:
  - WR_THRU=1: return the merged word, i.e. new bytes where i_wbe=1 and old bytes elsewhere.
  - WR_THRU=0: return the pre-write word.
  - In both modes the memory is updated.
REQ-026 SHALL wrap addresses naturally within DEPTH; there is no out-of-range case.

Reset
REQ-027 SHALL, on i_rstn=0, immediately and asynchronously set the state to CLR, the clear counter to 0, o_rdata to 0, o_rvalid to 0, all read-pipeline valid bits to 0, and o_init_busy to 1.
REQ-028 SHALL restart the clear from address 0 if reset is asserted mid-CLR or mid-read; any in-flight read is discarded.
REQ-029 SHALL NOT reset the memory array asynchronously; it is cleared only by the CLR sequence.

Structure
REQ-030 SHALL place the CLR/RUN state encoding and the RD_LAT and WR_THRU legal-value constants in the shared package sdpsram_pkg.
REQ-031 SHALL implement the clear engine (state, counter, o_init_busy) as the sub-module sdpsram_clr; the array, write masking, collision logic and read pipeline stay in sdpsram.

Verification
REQ-032 SHALL cover power-up clear: release reset with BW_ADDR=5 -> o_init_busy high for exactly 32 cycles; subsequent reads of addresses 0..31 all return 0.
REQ-033 SHALL cover write and read-back: write i to address i for i=0..31 with i_wbe=4'hF, then read 0..31 back-to-back -> o_rdata=i with continuous o_rvalid; latency is 1 cycle (RD_LAT=1) and 2 cycles (RD_LAT=2).
REQ-034 SHALL cover byte enables: write 32'hAABBCCDD to address 3, then 32'h11223344 with i_wbe=4'b0101 -> a read of address 3 returns 32'hAA22CC44.
REQ-035 SHALL cover collision: address 7 holds 32'h0; the same edge writes 32'hDEADBEEF and reads address 7 -> 32'hDEADBEEF with WR_THRU=1, 32'h0 with WR_THRU=0; a following read returns 32'hDEADBEEF in both modes.
REQ-036 SHALL cover output gating: i_roen=0 during a read of a nonzero word -> o_rdata=0 while o_rvalid=1; raising i_roen afterwards shows the held word.
REQ-037 SHALL cover reset mid-clear: assert i_rstn=0 at clear count 10 -> o_init_busy stays high; the clear restarts and lasts a full 32 cycles after release; o_rvalid stays 0 throughout.
